// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-to-1 mux select scanner.
// Imported by settle_counter and mux_select_scanner.
package mux_scan_pkg;

  localparam int NUM_INPUTS = 4;
  localparam int SEL_W      = 2;
  localparam int SETTLE_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage : mux_scan_pkg

// File: rtl/settle_counter.sv
// Slot settle counter: wraps from FIRST to END, tc flags the terminal value.
// COUNT_DOWN selects the direction; clr forces the start value.
module settle_counter
  import mux_scan_pkg::*;
#(
  parameter int WIDTH      = SETTLE_W,
  parameter int TERMINAL   = 1,
  parameter bit COUNT_DOWN = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(TERMINAL - 1);
  localparam logic [WIDTH-1:0] FIRST = COUNT_DOWN ? LAST : '0;
  localparam logic [WIDTH-1:0] END   = COUNT_DOWN ? '0 : LAST;

  logic [WIDTH-1:0] count_q, count_d;

  assign tc = (count_q == END);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr || (en && tc)) begin
      count_d = FIRST;
    end else if (en) begin
      count_d = COUNT_DOWN ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= FIRST;
    else       count_q <= count_d;
  end

endmodule : settle_counter

// File: rtl/mux_select_scanner.sv
// Drives the mux select through 0..3, samples Y per slot and publishes a 4-bit word.
// Optional feature: define MUX_SCAN_CONTINUOUS_EN for back-to-back scans without an IDLE gap.
module mux_select_scanner
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  Y,
  output logic [SEL_W-1:0]      S,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_INPUTS-1:0] word
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_INPUTS - 1);

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      k_q, k_d;
  logic [NUM_INPUTS-1:0] shadow_q, shadow_d;
  logic [NUM_INPUTS-1:0] word_q, word_d;
  logic                  done_q, done_d;
  logic                  scanning;
  logic                  slot_tc;
  logic                  slot_end;
  logic                  scan_end;
  logic                  continue_scan;

  assign scanning = (state_q == SCAN);
  assign slot_end = scanning && slot_tc;
  assign scan_end = slot_end && (k_q == LAST_SLOT);

`ifdef MUX_SCAN_CONTINUOUS_EN
  assign continue_scan = start;
`else
  assign continue_scan = 1'b0;
`endif

  settle_counter #(
    .WIDTH      (SETTLE_W),
    .TERMINAL   (SETTLE_CYCLES),
    .COUNT_DOWN (1'b0)
  ) u_settle (
    .clock (clock),
    .reset (reset),
    .clr   (~scanning),
    .en    (scanning),
    .tc    (slot_tc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: if (scan_end && !continue_scan) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = scanning;
  end

  always_comb begin
    k_d      = k_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    done_d   = 1'b0;
    if (slot_end) begin
      shadow_d[k_q] = Y;
      if (k_q == LAST_SLOT) begin
        // Publish including the bit captured on this very edge.
        word_d = shadow_d;
        done_d = 1'b1;
        k_d    = '0;
      end else begin
        k_d = k_q + SEL_W'(1);
      end
    end
  end

  // NOTE: the shadow register is reset too, so an aborted scan leaves no stale bits behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      k_q      <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      k_q      <= k_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      done_q   <= done_d;
    end
  end

  assign S    = k_q;
  assign done = done_q;
  assign word = word_q;

endmodule : mux_select_scanner
